// File: rtl/ebus_arb_pkg.sv
// Shared types and default sizing for the EBUS arbiter slice.
package ebus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EBOX_OWN,
    PI_OWN,
    TURN
  } ebus_arb_state_t;

  typedef enum logic {
    OWN_EBOX,
    OWN_PI
  } ebus_owner_t;

  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_TURN_CYCLES    = 1;
  localparam int DEF_CNT_W          = 11;

endpackage

// File: rtl/ebus_arb_timer.sv
// Saturating cycle counter with terminal-count compare; serves both the
// ownership watchdog and the turnaround gap.
module ebus_arb_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_value,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign tc = (cnt == tc_value);

endmodule

// File: rtl/ebus_arbiter.sv
// EBUS ownership arbiter between the EBOX (CON grant/release handshake) and
// PI function cycles, with fairness alternation, turnaround gap and watchdog.
module ebus_arbiter
  import ebus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TURN_CYCLES    = DEF_TURN_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic clk,
  input  logic CROBAR_N,
  input  logic EBOX_REQ,
  input  logic EBUS_REL,
  input  logic EBOX_HALTED,
  input  logic PI_REQ,
  input  logic PI_DONE,
  input  logic CLR_ERR,
  output logic EBUS_GRANT,
  output logic PI_GRANT,
  output logic EBUS_BUSY,
  output logic EBUS_TIMEOUT,
  output logic STRAY_REL
);

  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_TC    = CNT_W'(TURN_CYCLES - 1);

  ebus_arb_state_t  state;
  ebus_owner_t      last_owner;
  logic             tc;
  logic             tmr_clr;
  logic [CNT_W-1:0] tc_value;
  logic             ereq, preq, pick_pi, pick_ebox;
  logic             ebox_end, pi_end, turn_end;
  logic             timeout_set, stray_set;

  assign ereq      = EBOX_REQ & ~EBOX_HALTED;
  assign preq      = PI_REQ;
  assign pick_pi   = preq & (~ereq | (last_owner != OWN_PI));
  assign pick_ebox = ereq & ~pick_pi;

  // A release pulse on the same edge as terminal count is a clean release.
  assign ebox_end    = (state == EBOX_OWN) & (EBUS_REL | tc);
  assign pi_end      = (state == PI_OWN)   & (PI_DONE  | tc);
  assign turn_end    = (state == TURN)     & tc;
  assign timeout_set = ((state == EBOX_OWN) & tc & ~EBUS_REL) |
                       ((state == PI_OWN)   & tc & ~PI_DONE);
  assign stray_set   = (EBUS_REL & (state != EBOX_OWN)) |
                       (PI_DONE  & (state != PI_OWN));

  // Held at zero in IDLE so each OWN entry starts from a cleared count.
  assign tmr_clr  = (state == IDLE) | ebox_end | pi_end | turn_end;
  assign tc_value = (state == TURN) ? TURN_TC : TIMEOUT_TC;

  ebus_arb_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (CROBAR_N),
    .clr      (tmr_clr),
    .en       (1'b1),
    .tc_value (tc_value),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      state        <= IDLE;
      last_owner   <= OWN_EBOX;
      EBUS_GRANT   <= 1'b0;
      PI_GRANT     <= 1'b0;
      EBUS_BUSY    <= 1'b0;
      EBUS_TIMEOUT <= 1'b0;
      STRAY_REL    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_pi) begin
            state      <= PI_OWN;
            last_owner <= OWN_PI;
            PI_GRANT   <= 1'b1;
            EBUS_BUSY  <= 1'b1;
          end else if (pick_ebox) begin
            state      <= EBOX_OWN;
            last_owner <= OWN_EBOX;
            EBUS_GRANT <= 1'b1;
            EBUS_BUSY  <= 1'b1;
          end
        end
        EBOX_OWN: begin
          if (ebox_end) begin
            state      <= TURN;
            EBUS_GRANT <= 1'b0;
          end
        end
        PI_OWN: begin
          if (pi_end) begin
            state    <= TURN;
            PI_GRANT <= 1'b0;
          end
        end
        TURN: begin
          if (turn_end) begin
            state     <= IDLE;
            EBUS_BUSY <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          EBUS_GRANT <= 1'b0;
          PI_GRANT   <= 1'b0;
          EBUS_BUSY  <= 1'b0;
        end
      endcase

      // Sticky flags: a new event outranks a simultaneous clear.
      EBUS_TIMEOUT <= timeout_set | (EBUS_TIMEOUT & ~CLR_ERR);
      STRAY_REL    <= stray_set   | (STRAY_REL    & ~CLR_ERR);
    end
  end

endmodule

// File: tb/tb_ebus_arbiter.sv
// Scoreboard bench for ebus_arbiter: directed scenarios plus random traffic
// checked against an ownership-level reference model.
module tb_ebus_arbiter;

  localparam int TO = 8;
  localparam int TC = 1;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic CROBAR_N = 1'b1;
  logic EBOX_REQ = 1'b0, EBUS_REL = 1'b0, EBOX_HALTED = 1'b0;
  logic PI_REQ = 1'b0, PI_DONE = 1'b0, CLR_ERR = 1'b0;
  logic EBUS_GRANT, PI_GRANT, EBUS_BUSY, EBUS_TIMEOUT, STRAY_REL;

  always #5 clk = ~clk;

  ebus_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .TURN_CYCLES    (TC),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .CROBAR_N     (CROBAR_N),
    .EBOX_REQ     (EBOX_REQ),
    .EBUS_REL     (EBUS_REL),
    .EBOX_HALTED  (EBOX_HALTED),
    .PI_REQ       (PI_REQ),
    .PI_DONE      (PI_DONE),
    .CLR_ERR      (CLR_ERR),
    .EBUS_GRANT   (EBUS_GRANT),
    .PI_GRANT     (PI_GRANT),
    .EBUS_BUSY    (EBUS_BUSY),
    .EBUS_TIMEOUT (EBUS_TIMEOUT),
    .STRAY_REL    (STRAY_REL)
  );

  typedef struct packed {
    logic eg;
    logic pg;
    logic busy;
    logic tout;
    logic stray;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Model: owner 0 = nobody, 1 = EBOX, 2 = PI; held = cycles owned so far;
  // gap = turnaround cycles still to run.
  int   m_owner, m_held, m_gap;
  bit   m_last_pi, m_tout, m_stray;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_held = 0; m_gap = 0;
    m_last_pi = 1'b0; m_tout = 1'b0; m_stray = 1'b0;
  endtask

  task automatic model_step(input bit er, input bit rel, input bit halt,
                            input bit pr, input bit done, input bit clr);
    bit stray_now, tout_now;
    bit e_ok;
    stray_now = (rel && m_owner != 1) || (done && m_owner != 2);
    tout_now  = 1'b0;
    if (m_owner != 0) begin
      if ((m_owner == 1) ? rel : done) begin
        m_owner = 0; m_gap = TC;
      end else if (m_held == TO) begin
        m_owner = 0; m_gap = TC; tout_now = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      e_ok = er && !halt;
      if (pr && (!e_ok || !m_last_pi)) begin
        m_owner = 2; m_last_pi = 1'b1; m_held = 1;
      end else if (e_ok) begin
        m_owner = 1; m_last_pi = 1'b0; m_held = 1;
      end
    end
    m_tout  = tout_now  | (m_tout  & ~clr);
    m_stray = stray_now | (m_stray & ~clr);
  endtask

  task automatic cyc(input bit er, input bit rel, input bit halt,
                     input bit pr, input bit done, input bit clr);
    exp_t e;
    @(negedge clk);
    EBOX_REQ = er; EBUS_REL = rel; EBOX_HALTED = halt;
    PI_REQ = pr; PI_DONE = done; CLR_ERR = clr;
    model_step(er, rel, halt, pr, done, clr);
    e.eg    = (m_owner == 1);
    e.pg    = (m_owner == 2);
    e.busy  = (m_owner != 0) || (m_gap > 0);
    e.tout  = m_tout;
    e.stray = m_stray;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares the outputs produced by each edge against the model.
  always @(posedge clk) begin
    exp_t e;
    #2;
    check("grant_exclusive", EBUS_GRANT & PI_GRANT, 1'b0);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("EBUS_GRANT",   EBUS_GRANT,   e.eg);
      check("PI_GRANT",     PI_GRANT,     e.pg);
      check("EBUS_BUSY",    EBUS_BUSY,    e.busy);
      check("EBUS_TIMEOUT", EBUS_TIMEOUT, e.tout);
      check("STRAY_REL",    STRAY_REL,    e.stray);
    end
  end

  initial begin
    model_reset();
    #1 CROBAR_N = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_ebus_grant", EBUS_GRANT,   1'b0);
    check("reset_pi_grant",   PI_GRANT,     1'b0);
    check("reset_busy",       EBUS_BUSY,    1'b0);
    check("reset_timeout",    EBUS_TIMEOUT, 1'b0);
    check("reset_stray",      STRAY_REL,    1'b0);
    @(negedge clk) CROBAR_N = 1'b1;

    // Basic EBOX grant, release, turnaround.
    idle(2);
    cyc(1, 0, 0, 0, 0, 0);
    idle(6);
    cyc(0, 1, 0, 0, 0, 0);
    idle(3);

    // Contention alternation with both requests held.
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      if (m_owner == 2) cyc(1, 0, 0, 1, 1, 0);
      else              cyc(1, 0, 0, 1, 0, 0);
      if (m_owner == 1) cyc(1, 1, 0, 1, 0, 0);
    end
    idle(1);
    if (m_owner == 1) cyc(0, 1, 0, 0, 0, 0);
    if (m_owner == 2) cyc(0, 0, 0, 0, 1, 0);
    idle(3);

    // Watchdog timeout, clear, then release on the final owned cycle.
    cyc(1, 0, 0, 0, 0, 0);
    idle(11);
    cyc(0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0);
    idle(7);
    cyc(0, 1, 0, 0, 0, 0);
    idle(4);

    // Stray releases.
    cyc(0, 1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(1);
    cyc(0, 1, 0, 0, 0, 1);
    idle(3);

    // Halted EBOX is not granted until the halt drops.
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(3);

    // Asynchronous reset in the middle of EBOX ownership.
    @(posedge clk);
    #3;
    CROBAR_N = 1'b0;
    #1;
    check("async_rst_grant", EBUS_GRANT, 1'b0);
    check("async_rst_busy",  EBUS_BUSY,  1'b0);
    model_reset();
    @(negedge clk) CROBAR_N = 1'b1;
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 3) != 0, ($urandom % 12) == 0, ($urandom % 8) == 0,
          ($urandom % 2) == 0, ($urandom % 12) == 0, ($urandom % 10) == 0);
    end
    idle(2);

    repeat (2) @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ebus_arbiter.md
Name: ebus_arbiter

Overview:
- Grants EBUS ownership to either the EBOX (CON side) or the PI board's interrupt-function cycle.
- Receives the CON release (EBUS_REL) and returns EBUS_GRANT; it is the responder end of the CON EBUS grant/release handshake.
- Adds PI/EBOX fairness alternation, a dead turnaround gap between owners, and an ownership watchdog.
- Sits between CON, PI and the EBUS transceiver enables.

Parameters:
- TIMEOUT_CYCLES, 1024, maximum cycles one owner may hold the bus before forced release (must be ≥2).
- TURN_CYCLES, 1, dead cycles between one owner's release and the next grant (≥1).
- CNT_W, 11, width of the watchdog/turnaround counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- CROBAR_N  in  1  reset, asynchronous assert, active-low.
- EBOX_REQ  in  1  level request from CON; held until granted.
- EBUS_REL  in  1  one-cycle pulse from CON ending EBOX ownership.
- EBOX_HALTED  in  1  when 1, EBOX_REQ is not honoured from IDLE.
- PI_REQ  in  1  level request from PI for a function cycle.
- PI_DONE  in  1  one-cycle pulse ending PI ownership.
- CLR_ERR  in  1  clears sticky error flags.
- EBUS_GRANT  out  1  EBOX owns the bus (to CON).
- PI_GRANT  out  1  PI owns the bus.
- EBUS_BUSY  out  1  bus is owned or in turnaround.
- EBUS_TIMEOUT  out  1  sticky: watchdog forced a release.
- STRAY_REL  out  1  sticky: EBUS_REL or PI_DONE arrived with no matching grant.

Behaviour:
- Reset (async, CROBAR_N=0):
  - State IDLE; all outputs 0; counter 0; last_owner=EBOX.
  - Reset mid-ownership drops the grant immediately, with no turnaround.
- All outputs are registered. Request to grant is 1 cycle: a request sampled in IDLE on edge N gives the grant visible after edge N.
- States: IDLE, EBOX_OWN, PI_OWN, TURN.
- IDLE arbitration:
  - Eligible: ereq = EBOX_REQ & ~EBOX_HALTED; preq = PI_REQ.
  - Only preq → PI_OWN. Only ereq → EBOX_OWN. Neither → stay.
  - Both → PI_OWN unless last_owner=PI, then EBOX_OWN.
  - On entry to either OWN state: counter cleared; last_owner updated.
- EBOX_OWN:
  - EBUS_GRANT=1. Counter increments each cycle.
  - EBUS_REL=1 → TURN; grant is 0 the next cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without EBUS_REL → TURN and set EBUS_TIMEOUT.
  - EBUS_REL and timeout in the same cycle: release wins, no timeout flag.
  - Deasserting EBOX_REQ while owning is ignored; only EBUS_REL releases.
- PI_OWN: same as EBOX_OWN with PI_GRANT and PI_DONE.
- TURN:
  - No grant; EBUS_BUSY=1; counter cleared on entry.
  - Stay TURN_CYCLES cycles, then IDLE. Requests arriving here wait.
  - The earliest regrant is therefore TURN_CYCLES+1 cycles after the release edge.
- EBUS_BUSY = (state != IDLE).
- EBUS_GRANT and PI_GRANT are never both 1. The bench asserts this as an invariant.
- STRAY_REL sets when:
  - EBUS_REL=1 in any state but EBOX_OWN, or
  - PI_DONE=1 in any state but PI_OWN.
  - A stray pulse causes no state change.
- Sticky flags:
  - CLR_ERR clears both flags.
  - A set and a CLR_ERR in the same cycle leaves the flag set (set wins).
- Counter saturates; it never wraps.

Decomposition:
- Package ebus_arb_pkg:
  - enum ebus_arb_state_t {IDLE, EBOX_OWN, PI_OWN, TURN}.
  - enum ebus_owner_t {OWN_EBOX, OWN_PI}.
  - Default parameter constants.
- Sub-module ebus_arb_timer: CNT_W-bit saturating counter with clear/enable inputs and a terminal-count compare output. It is shared by the watchdog and turnaround uses.

Test Plan:
- Reset release, then EBOX_REQ=1 at cycle 3 → EBUS_GRANT=1 at cycle 4. EBUS_REL pulse at cycle 10 → grant 0 at cycle 11, EBUS_BUSY=1 at cycle 11, IDLE at cycle 12 with TURN_CYCLES=1.
- EBOX_REQ and PI_REQ both high from IDLE after reset → PI_GRANT first. After PI_DONE and turnaround, EBOX_GRANT follows. On the third arbitration with both high → PI again (alternation).
- TIMEOUT_CYCLES=8, grant EBOX, never release → grant drops after 8 owned cycles and EBUS_TIMEOUT=1. CLR_ERR → 0. Repeat with EBUS_REL on the 8th cycle → EBUS_TIMEOUT stays 0.
- EBUS_REL pulse in IDLE → STRAY_REL=1, state unchanged. PI_DONE during EBOX_OWN → STRAY_REL=1, EBUS_GRANT stays 1.
- EBOX_HALTED=1 with EBOX_REQ=1 for 20 cycles → no grant. Drop EBOX_HALTED → grant 1 cycle later.
- CROBAR_N asserted asynchronously mid-EBOX_OWN → EBUS_GRANT=0 immediately. After release, the first grant obeys the 1-cycle latency and last_owner=EBOX.
